// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with a 2-entry skid buffer on the output
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_fun3,
  output logic            out_reg_write,
  output logic            out_load,
  output logic            out_store,
  output logic            out_mem_en,
  output logic            out_branch,
  output logic            out_next_sel,
  output logic            out_operand_a,
  output logic            out_operand_b,
  output logic [1:0]      out_mem_to_reg,
  output logic [2:0]      out_imm_sel,
  output logic [4:0]      out_alu_control,
  output logic            out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_PASS_B = 5'b01111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fun3;
    logic            reg_write;
    logic            load;
    logic            store;
    logic            mem_en;
    logic            branch;
    logic            next_sel;
    logic            operand_a;
    logic            operand_b;
    logic [1:0]      mem_to_reg;
    logic [2:0]      imm_sel;
    logic [4:0]      alu_control;
    logic            illegal;
  } entry_t;

  // funct3 -> ALU op for register/immediate arithmetic with the base funct7
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic       illegal;
  logic [4:0] alu_raw;
  entry_t     dec;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);

  // ALU selection and legality checks on opcode/funct3/funct7
  always_comb begin
    illegal = 1'b0;
    alu_raw = ALU_ADD;
    case (opcode)
      OP_R: begin
        case (funct7)
          F7_BASE: alu_raw = base_alu(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      alu_raw = ALU_SUB;
            else if (funct3 == 3'b101) alu_raw = ALU_SRA;
            else                       illegal = 1'b1;
          end
          F7_MUL: begin
            if (EN_M) alu_raw = {2'b10, funct3};
            else      illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_I: begin
        alu_raw = base_alu(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       alu_raw = ALU_SRA;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_STORE:  illegal = (funct3 > 3'b010);
      OP_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_JALR:   illegal = (funct3 != 3'b000);
      OP_JAL, OP_AUIPC: illegal = 1'b0;
      OP_LUI:    alu_raw = ALU_PASS_B;
      default:   illegal = 1'b1;
    endcase
  end

  // Control bundle; illegal entries lose every side effect and their ALU op
  always_comb begin
    dec.pc          = in_pc;
    dec.rd          = in_instr[11:7];
    dec.rs1         = in_instr[19:15];
    dec.rs2         = in_instr[24:20];
    dec.fun3        = funct3;
    dec.reg_write   = !illegal && (is_r || is_i || is_load || is_jal || is_jalr || is_lui || is_auipc);
    dec.load        = !illegal && is_load;
    dec.store       = !illegal && is_store;
    dec.mem_en      = !illegal && is_store;
    dec.branch      = !illegal && is_branch;
    dec.next_sel    = !illegal && (is_jal || is_jalr);
    dec.operand_a   = is_branch || is_jal || is_auipc;
    dec.operand_b   = !is_r;
    dec.mem_to_reg  = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
    dec.imm_sel     = is_store ? 3'b001 :
                      is_branch ? 3'b010 :
                      is_jal ? 3'b011 :
                      (is_lui || is_auipc) ? 3'b100 : 3'b000;
    dec.alu_control = illegal ? ALU_ADD : alu_raw;
    dec.illegal     = illegal;
  end

  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  entry_t     slot0_q, slot0_d;
  entry_t     slot1_q, slot1_d;
  logic       enq, deq;

  assign enq = in_valid && in_ready_q;
  assign deq = (cnt_q != 2'd0) && out_ready;

  // Two-slot FIFO: slot0 is the head, slot1 only holds the second entry
  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (cnt_q == 2'd0) slot0_d = dec;
          else               slot1_d = dec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            slot0_d = dec;
          end else begin
            slot0_d = slot1_q;
            slot1_d = dec;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
    in_ready_d = (cnt_d != 2'd2);
  end

  // State registers; reset clears the buffer and zeroes the head fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
      slot0_q    <= '0;
      slot1_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = (cnt_q != 2'd0);
  assign out_pc          = slot0_q.pc;
  assign out_rd          = slot0_q.rd;
  assign out_rs1         = slot0_q.rs1;
  assign out_rs2         = slot0_q.rs2;
  assign out_fun3        = slot0_q.fun3;
  assign out_reg_write   = slot0_q.reg_write;
  assign out_load        = slot0_q.load;
  assign out_store       = slot0_q.store;
  assign out_mem_en      = slot0_q.mem_en;
  assign out_branch      = slot0_q.branch;
  assign out_next_sel    = slot0_q.next_sel;
  assign out_operand_a   = slot0_q.operand_a;
  assign out_operand_b   = slot0_q.operand_b;
  assign out_mem_to_reg  = slot0_q.mem_to_reg;
  assign out_imm_sel     = slot0_q.imm_sel;
  assign out_alu_control = slot0_q.alu_control;
  assign out_illegal     = slot0_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench for decode_stage against a queue-based reference model
module tb_decode_stage;

  localparam int BW = 69;
  // funct3-indexed base ALU ops: ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [39:0] BASE_ALU = {5'd9, 5'd8, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd0};

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [1:0][BW-1:0] got;
  logic [1:0]  ov, ir;
  bit          checking = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [2*BW-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Instance g has EN_M = g; both see the same stimulus
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] o_pc;
    logic [4:0]  o_rd, o_rs1, o_rs2, o_alu;
    logic [2:0]  o_f3, o_imm;
    logic [1:0]  o_m2r;
    logic        o_rw, o_ld, o_st, o_me, o_br, o_ns, o_oa, o_ob, o_ill, o_v, o_r;
    decode_stage #(.XLEN(32), .EN_M(g == 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(o_r), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(o_v), .out_ready(out_ready), .out_pc(o_pc),
      .out_rd(o_rd), .out_rs1(o_rs1), .out_rs2(o_rs2), .out_fun3(o_f3),
      .out_reg_write(o_rw), .out_load(o_ld), .out_store(o_st), .out_mem_en(o_me),
      .out_branch(o_br), .out_next_sel(o_ns), .out_operand_a(o_oa), .out_operand_b(o_ob),
      .out_mem_to_reg(o_m2r), .out_imm_sel(o_imm), .out_alu_control(o_alu), .out_illegal(o_ill)
    );
    assign got[g] = {o_pc, o_rd, o_rs1, o_rs2, o_f3, o_rw, o_ld, o_st, o_me, o_br, o_ns,
                     o_oa, o_ob, o_m2r, o_imm, o_alu, o_ill};
    assign ov[g] = o_v;
    assign ir[g] = o_r;
  end

  task automatic check_eq(input string tag, input logic [79:0] got_v, input logic [79:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules
  function automatic logic [BW-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
    logic [6:0] op, f7;
    logic [2:0] f3, imm;
    logic [39:0] tab;
    logic [4:0] alu;
    logic [1:0] m2r;
    bit r, i, ld, st, br, jl, jr, lu, au, ill, rw, ns;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; tab = BASE_ALU;
    r = (op == 7'h33); i = (op == 7'h13); ld = (op == 7'h03); st = (op == 7'h23);
    br = (op == 7'h63); jl = (op == 7'h6F); jr = (op == 7'h67); lu = (op == 7'h37); au = (op == 7'h17);
    ill = !(r || i || ld || st || br || jl || jr || lu || au);
    alu = lu ? 5'b01111 : 5'b00000;
    if (r) begin
      if (f7 == 7'h00)                  alu = tab[int'(f3)*5 +: 5];
      else if (f7 == 7'h20 && f3 == 0)  alu = 5'b00001;
      else if (f7 == 7'h20 && f3 == 5)  alu = 5'b00111;
      else if (f7 == 7'h01 && en_m)     alu = {2'b10, f3};
      else                              ill = 1;
    end
    if (i) begin
      alu = tab[int'(f3)*5 +: 5];
      if (f3 == 1 && f7 != 0) ill = 1;
      if (f3 == 5) begin
        if (f7 == 7'h20)   alu = 5'b00111;
        else if (f7 != 0)  ill = 1;
      end
    end
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ill = 1;
    if (st && f3 > 2) ill = 1;
    if (br && (f3 == 2 || f3 == 3)) ill = 1;
    if (jr && f3 != 0) ill = 1;
    rw  = (r || i || ld || jl || jr || lu || au) && !ill;
    ns  = (jl || jr) && !ill;
    m2r = ld ? 2'd1 : ((jl || jr) ? 2'd2 : 2'd0);
    imm = st ? 3'd1 : br ? 3'd2 : jl ? 3'd3 : (lu || au) ? 3'd4 : 3'd0;
    if (ill) alu = 5'b00000;
    return {pc, ins[11:7], ins[19:15], ins[24:20], f3, rw, ld && !ill, st && !ill, st && !ill,
            br && !ill, ns, br || jl || au, !r, m2r, imm, alu, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] rv;
    logic [6:0] op, f7;
    rv = $urandom();
    case ($urandom_range(0, 9))
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23; 4: op = 7'h63;
      5: op = 7'h6F; 6: op = 7'h67; 7: op = 7'h37; 8: op = 7'h17;
      default: op = rv[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01;
      default: f7 = rv[31:25];
    endcase
    return {f7, rv[24:7], op};
  endfunction

  // Compare against the model, then advance the model to the next edge
  always @(negedge clk) begin
    bit do_deq, do_enq;
    if (checking) begin
      for (int g = 0; g < 2; g++) begin
        check_eq($sformatf("out_valid[%0d]", g), ov[g], exp_q.size() != 0);
        check_eq($sformatf("in_ready[%0d]", g), ir[g], exp_q.size() < 2);
        if (exp_q.size() != 0)
          check_eq($sformatf("head[%0d]", g), got[g], exp_q[0][g*BW +: BW]);
      end
      if (!rst_n || flush) begin
        exp_q.delete();
      end else begin
        do_deq = (exp_q.size() != 0) && out_ready;
        do_enq = in_valid && (exp_q.size() < 2);
        if (do_deq) void'(exp_q.pop_front());
        if (do_enq) exp_q.push_back({ref_decode(in_instr, in_pc, 1'b1), ref_decode(in_instr, in_pc, 1'b0)});
      end
    end
  end

  task automatic offer(input logic [31:0] ins);
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = ins; in_pc = $urandom();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq({tag, "_fields"}, got[g], '0);
      check_eq({tag, "_valid"}, ov[g], 1'b0);
      check_eq({tag, "_ready"}, ir[g], 1'b1);
    end
  endtask

  initial begin
    logic [31:0] pc_a;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    checking = 1'b1;

    offer(32'h002081B3);
    check_eq("add_valid", ov[1], 1'b1);
    check_eq("add_alu", got[1][5:1], 5'b00000);
    check_eq("add_rw", got[1][18], 1'b1);
    check_eq("add_opb", got[1][11], 1'b0);
    check_eq("add_regs", got[1][36:22], {5'd3, 5'd1, 5'd2});

    offer(32'h4020D193);
    check_eq("srai_alu", got[0][5:1], 5'b00111);
    check_eq("srai_imm", got[0][8:6], 3'b000);
    check_eq("srai_opb", got[0][11], 1'b1);
    offer(32'h0020D193);
    check_eq("srli_alu", got[0][5:1], 5'b00110);

    offer(32'h022081B3);
    check_eq("mul_m_alu", got[1][5:1], 5'b10000);
    check_eq("mul_m_ill", got[1][0], 1'b0);
    check_eq("mul_nom_ill", got[0][0], 1'b1);
    check_eq("mul_nom_rw", got[0][18], 1'b0);
    check_eq("mul_nom_alu", got[0][5:1], 5'b00000);

    offer(32'h0000007F);
    check_eq("badop_ill", got[0][0], 1'b1);
    check_eq("badop_mem", got[0][16:15], 2'b00);
    offer(32'h0020B023);
    check_eq("sw3_ill", got[0][0], 1'b1);
    check_eq("sw3_mem", got[0][16:15], 2'b00);
    offer(32'h008000EF);
    check_eq("jal_m2r", got[0][10:9], 2'b10);
    check_eq("jal_imm", got[0][8:6], 3'b011);
    check_eq("jal_ns", got[0][13], 1'b1);
    check_eq("jal_opa", got[0][12], 1'b1);

    // Backpressure: three back-to-back offers, only two fit
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; pc_a = in_pc;
    @(posedge clk); #1;
    in_instr = 32'h00A10113; in_pc = 32'h104;
    @(posedge clk); #1;
    in_instr = 32'h00F18193; in_pc = 32'h108;
    check_eq("bp_ready_low", ir[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_ready_held", ir[1], 1'b0);
    check_eq("bp_head_pc", got[0][68:37], pc_a);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Flush with two buffered entries and a concurrent offer
    #1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1; in_instr = 32'h00100093;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_valid", ov[0], 1'b0);
    check_eq("flush_ready", ir[0], 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Reset while the buffer is full
    #1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00C00513;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midreset");
    rst_n = 1'b1;

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst_n     = ($urandom_range(0, 500) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom();
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
